// File: rtl/soc_msp430_switch_debounce.sv
// Switch input conditioning for the MSP430 GPIO port 1 switch bits: two-flop
// synchroniser, shared sample-tick prescaler and per-channel debounce FSMs.
module soc_msp430_switch_debounce #(
    parameter int   NUM_SW       = 4,
    parameter int   PRESCALE     = 1000,
    parameter int   STABLE_TICKS = 8,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              debounce_en,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_clean,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              sw_busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHECKING = 1'b1
    } state_e;

    logic [NUM_SW-1:0] sync1_q, sync1_d;
    logic [NUM_SW-1:0] sync2_q, sync2_d;
    logic [NUM_SW-1:0] clean_q, clean_d;
    logic [NUM_SW-1:0] rise_q, rise_d;
    logic [NUM_SW-1:0] fall_q, fall_d;
    logic [PW-1:0]     pre_q, pre_d;
    state_e            state_q [NUM_SW];
    state_e            state_d [NUM_SW];
    logic [CW-1:0]     cnt_q   [NUM_SW];
    logic [CW-1:0]     cnt_d   [NUM_SW];
    logic              tick;

    // Free-running prescaler; parked at zero while debouncing is bypassed.
    always_comb begin
        tick = (pre_q == PRE_LAST);
        if (!debounce_en || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        for (int i = 0; i < NUM_SW; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!debounce_en) begin
                clean_d[i] = sync2_q[i];
                state_d[i] = ST_STABLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_STABLE: begin
                        // The tick of the entry cycle is deliberately not counted.
                        if (sync2_q[i] != clean_q[i]) begin
                            state_d[i] = ST_CHECKING;
                            cnt_d[i]   = '0;
                        end
                    end
                    ST_CHECKING: begin
                        if (sync2_q[i] == clean_q[i]) begin
                            state_d[i] = ST_STABLE;
                            cnt_d[i]   = '0;
                        end else if (tick) begin
                            if (cnt_q[i] == CNT_LAST) begin
                                clean_d[i] = sync2_q[i];
                                state_d[i] = ST_STABLE;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
        // Pulses are registered alongside the new level so both appear together.
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
    end

    always_comb begin
        sw_busy = 1'b0;
        for (int i = 0; i < NUM_SW; i++) begin
            sw_busy = sw_busy | (state_q[i] == ST_CHECKING);
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            sync1_q <= {NUM_SW{RESET_LEVEL}};
            sync2_q <= {NUM_SW{RESET_LEVEL}};
            clean_q <= {NUM_SW{RESET_LEVEL}};
            rise_q  <= '0;
            fall_q  <= '0;
            pre_q   <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pre_q   <= pre_d;
            for (int i = 0; i < NUM_SW; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign sw_clean = clean_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;

endmodule

// File: tb/tb_soc_msp430_switch_debounce.sv
// Bench for soc_msp430_switch_debounce: a PRESCALE=4/STABLE_TICKS=3 instance
// checked through an edge-event scoreboard, plus a PRESCALE=1/STABLE_TICKS=1 instance.
module tb_soc_msp430_switch_debounce;

  localparam int EW = 44;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic [3:0] raw;
  logic [3:0] raw1;
  logic [3:0] sw_clean, sw_rise, sw_fall;
  logic       sw_busy;
  logic [3:0] clean1, rise1, fall1;
  logic       busy1;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Entry layout: {clean[3:0], rise[3:0], fall[3:0], first_cyc[15:0], last_cyc[15:0]}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  logic [3:0]    model_clean;

  soc_msp430_switch_debounce #(
    .NUM_SW(4), .PRESCALE(4), .STABLE_TICKS(3), .RESET_LEVEL(1'b0)
  ) dut (
    .mclk(clk), .puc_rst(rst), .debounce_en(en), .sw_raw(raw),
    .sw_clean(sw_clean), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_busy(sw_busy)
  );

  soc_msp430_switch_debounce #(
    .NUM_SW(4), .PRESCALE(1), .STABLE_TICKS(1), .RESET_LEVEL(1'b0)
  ) dut_fast (
    .mclk(clk), .puc_rst(rst), .debounce_en(en), .sw_raw(raw1),
    .sw_clean(clean1), .sw_rise(rise1), .sw_fall(fall1), .sw_busy(busy1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [3:0] c, input logic [3:0] r, input logic [3:0] f,
                          input int lo, input int hi);
    exp_q.push_back({c, r, f, 16'(lo), 16'(hi)});
  endtask

  task automatic drain(input int max_cyc);
    for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
  endtask

  // Any pulse on the main instance must match the oldest expected edge event.
  always @(negedge clk) begin
    if ((sw_rise | sw_fall) != 4'b0000) begin
      check_eq("rise_and_fall_overlap", sw_rise & sw_fall, 4'b0000);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {sw_rise, sw_fall}, 8'h00);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("pulse_clean", sw_clean, exp_e[43:40]);
        check_eq("pulse_rise", sw_rise, exp_e[39:36]);
        check_eq("pulse_fall", sw_fall, exp_e[35:32]);
        check_eq("pulse_window", (cyc >= int'(exp_e[31:16])) && (cyc <= int'(exp_e[15:0])), 1'b1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    en = 1'b1;
    raw = 4'b0000;
    raw1 = 4'b0000;
    step(3);
    check_eq("rst_clean", sw_clean, 4'b0000);
    check_eq("rst_rise", sw_rise, 4'b0000);
    check_eq("rst_fall", sw_fall, 4'b0000);
    check_eq("rst_busy", sw_busy, 1'b0);
    check_eq("rst_clean_fast", clean1, 4'b0000);
    rst = 1'b0;
    step(2);

    // Fast build: step after edge N is visible at edge N+4.
    raw1 = 4'b0001;
    step(3);
    check_eq("fast_not_yet", clean1, 4'b0000);
    step(1);
    check_eq("fast_clean", clean1, 4'b0001);
    check_eq("fast_rise", rise1, 4'b0001);
    step(1);
    check_eq("fast_rise_one_cycle", rise1, 4'b0000);
    raw1 = 4'b0000;
    step(4);
    check_eq("fast_fall", fall1, 4'b0001);
    check_eq("fast_clean_low", clean1, 4'b0000);

    // Clean press on channel 0.
    n = cyc;
    raw = 4'b0001;
    push_exp(4'b0001, 4'b0001, 4'b0000, n + 12, n + 15);
    step(2);
    check_eq("t1_busy_before", sw_busy, 1'b0);
    step(1);
    check_eq("t1_busy", sw_busy, 1'b1);
    drain(20);
    check_eq("t1_clean", sw_clean, 4'b0001);
    check_eq("t1_busy_after", sw_busy, 1'b0);

    // Six-cycle glitch on channel 1 is rejected.
    n = cyc;
    raw = 4'b0011;
    step(6);
    raw = 4'b0001;
    step(2);
    check_eq("t2_busy_held", sw_busy, 1'b1);
    step(1);
    check_eq("t2_busy_drop", sw_busy, 1'b0);
    step(20);
    check_eq("t2_clean", sw_clean, 4'b0001);

    // Build 0011, then swap to 1100 in one step.
    n = cyc;
    raw = 4'b0011;
    push_exp(4'b0011, 4'b0010, 4'b0000, n + 12, n + 15);
    drain(20);
    n = cyc;
    raw = 4'b1100;
    push_exp(4'b1100, 4'b1100, 4'b0011, n + 12, n + 15);
    drain(20);
    check_eq("t3_clean", sw_clean, 4'b1100);

    // Reset while channel 0 is being checked: pending change is dropped.
    raw = 4'b1101;
    step(5);
    check_eq("t4_busy", sw_busy, 1'b1);
    rst = 1'b1;
    step(1);
    check_eq("t4_rst_clean", sw_clean, 4'b0000);
    check_eq("t4_rst_busy", sw_busy, 1'b0);
    check_eq("t4_rst_pulses", {sw_rise, sw_fall}, 8'h00);
    n = cyc;
    rst = 1'b0;
    push_exp(4'b1101, 4'b1101, 4'b0000, n + 12, n + 15);
    step(11);
    check_eq("t4_not_early", sw_clean, 4'b0000);
    drain(20);
    check_eq("t4_clean", sw_clean, 4'b1101);

    // Bypass: channel 3 follows the synchroniser, one pulse per toggle.
    en = 1'b0;
    model_clean = 4'b1101;
    step(1);
    for (int t = 0; t < 6; t++) begin
      n = cyc;
      raw[3] = ~raw[3];
      model_clean[3] = ~model_clean[3];
      push_exp(model_clean, {model_clean[3], 3'b000}, {~model_clean[3], 3'b000}, n + 3, n + 3);
      step(1);
      check_eq("t5_busy", sw_busy, 1'b0);
      step(2);
    end
    drain(6);
    check_eq("t5_clean", sw_clean, model_clean);
    en = 1'b1;
    step(20);
    check_eq("t5_exit_clean", sw_clean, 4'b1101);
    check_eq("t5_exit_busy", sw_busy, 1'b0);

    // After bypass exit the debounce path is fully back in service.
    n = cyc;
    raw = 4'b0001;
    push_exp(4'b0001, 4'b0000, 4'b1100, n + 12, n + 15);
    drain(20);
    check_eq("t6_clean", sw_clean, 4'b0001);

    step(5);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
